flac_frame_sequencer: RTL and testbench

Controller that splits a long PCM sample buffer into FLAC blocks and runs the fixed-predictor encoder core once per block. It drives the core's reset, numSamples, iAddressStart and oAddressStart, waits for the core's done, then chains each block's output bitstream directly after the previous one in output memory. It sits between the host/top-level start logic and the encoder core. It is the encoder's only sequencer.

---
 rtl/flac_pkg.sv | 11 +
 rtl/flac_frame_sequencer_if.sv | 12 +
 rtl/flac_seq_watchdog.sv | 19 +
 rtl/flac_frame_sequencer.sv | 113 +++++++++++
 tb/tb_flac_frame_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/flac_pkg.sv
// flac_pkg: shared widths, sequencer states and frame-length helper
package flac_pkg;
  localparam int ADDR_W = 16;
  localparam int SAMPLE_W = 16;
  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_LOAD, SEQ_GUARD, SEQ_RUN, SEQ_COMMIT, SEQ_DONE, SEQ_ERROR
  } seqState_t;
  function automatic logic [SAMPLE_W-1:0] frameLen(input logic [SAMPLE_W-1:0] remaining, input logic [SAMPLE_W-1:0] blockSize);
    return remaining < blockSize ? remaining : blockSize;
  endfunction
endpackage

// File: rtl/flac_frame_sequencer_if.sv
// flac_frame_sequencer_if: control bus between the frame sequencer and the encoder core
interface flac_frame_sequencer_if;
  import flac_pkg::*;
  logic oEncReset;
  logic [SAMPLE_W-1:0] oEncNumSamples;
  logic [ADDR_W-1:0] oEncInAddrStart;
  logic [ADDR_W-1:0] oEncOutAddrStart;
  logic iEncDone;
  logic [ADDR_W-1:0] iEncOutAddr;
  modport master(output oEncReset, oEncNumSamples, oEncInAddrStart, oEncOutAddrStart, input iEncDone, iEncOutAddr);
  modport slave(input oEncReset, oEncNumSamples, oEncInAddrStart, oEncOutAddrStart, output iEncDone, iEncOutAddr);
endinterface

// File: rtl/flac_seq_watchdog.sv
// flac_seq_watchdog: loadable per-frame cycle counter flagging the cycle it reaches LIMIT
module flac_seq_watchdog #(
  parameter logic [31:0] LIMIT = 32'd1000000
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        clear,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] loadValue,
  output logic        terminal
);
  logic [31:0] count;
  // terminal fires on the enabled cycle whose increment lands on LIMIT
  assign terminal = enable && count == LIMIT - 32'd1;
  // clear has priority over load, load over counting
  always_ff @(posedge iClock)
    count <= iReset || clear ? '0 : load ? loadValue : enable ? count + 32'd1 : count;
endmodule

// File: rtl/flac_frame_sequencer.sv
// flac_frame_sequencer: splits a sample stream into blocks and runs the encoder core once per block
module flac_frame_sequencer
  import flac_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] BLOCK_SIZE = 16'd4096,
  parameter int RESET_CYCLES = 2,
  parameter logic [ADDR_W-1:0] OUT_LIMIT = 16'hFFF0,
  parameter logic [31:0] MAX_FRAME_CYCLES = 32'd1000000
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic [SAMPLE_W-1:0] iTotalSamples,
  input  logic [ADDR_W-1:0]   iInBase,
  input  logic [ADDR_W-1:0]   iOutBase,
  flac_frame_sequencer_if.master enc,
  output logic [15:0]         oFrameIndex,
  output logic                oFrameDone,
  output logic                oBusy,
  output logic                oDone,
  output logic                oError,
  output logic [ADDR_W-1:0]   oOutEnd
);
  localparam logic [7:0] RC_LAST = 8'(RESET_CYCLES - 1);
  seqState_t state;
  logic [SAMPLE_W-1:0] remaining;
  logic [ADDR_W-1:0] inPtr, outPtr;
  logic [7:0] rstCnt;
  logic ovf, wdTerminal;
  flac_seq_watchdog #(.LIMIT(MAX_FRAME_CYCLES)) u_watchdog (
    .iClock(iClock), .iReset(iReset), .clear(state == SEQ_GUARD), .enable(state == SEQ_RUN),
    .load(1'b0), .loadValue(32'd0), .terminal(wdTerminal)
  );
  // frame sequencing FSM; outputs are registered to reflect the state being entered
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= SEQ_IDLE;
      enc.oEncReset <= 1'b1;
      enc.oEncNumSamples <= '0;
      enc.oEncInAddrStart <= '0;
      enc.oEncOutAddrStart <= '0;
      remaining <= '0;
      inPtr <= '0;
      outPtr <= '0;
      rstCnt <= '0;
      ovf <= 1'b0;
      oFrameIndex <= '0;
      oFrameDone <= 1'b0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oError <= 1'b0;
      oOutEnd <= '0;
    end else begin
      oFrameDone <= 1'b0;
      case (state)
        SEQ_IDLE, SEQ_DONE, SEQ_ERROR: if (iStart) begin
          remaining <= iTotalSamples;
          inPtr <= iInBase;
          outPtr <= iOutBase;
          oFrameIndex <= '0;
          rstCnt <= '0;
          oError <= 1'b0;
          oDone <= iTotalSamples == '0;
          oBusy <= iTotalSamples != '0;
          if (iTotalSamples == '0) oOutEnd <= iOutBase;
          state <= iTotalSamples == '0 ? SEQ_DONE : SEQ_LOAD;
        end
        SEQ_LOAD: begin
          enc.oEncNumSamples <= frameLen(remaining, BLOCK_SIZE);
          enc.oEncInAddrStart <= inPtr;
          enc.oEncOutAddrStart <= outPtr;
          rstCnt <= rstCnt + 8'd1;
          if (rstCnt == RC_LAST) begin
            state <= SEQ_GUARD;
            enc.oEncReset <= 1'b0;
          end
        end
        SEQ_GUARD: state <= SEQ_RUN;
        SEQ_RUN: if (enc.iEncDone) begin
          state <= SEQ_COMMIT;
          enc.oEncReset <= 1'b1;
          oFrameDone <= 1'b1;
          oOutEnd <= enc.iEncOutAddr + 16'd1;
          ovf <= enc.iEncOutAddr >= OUT_LIMIT;
        end else if (wdTerminal) begin
          state <= SEQ_ERROR;
          enc.oEncReset <= 1'b1;
          oBusy <= 1'b0;
          oError <= 1'b1;
        end
        SEQ_COMMIT: if (ovf) begin
          state <= SEQ_ERROR;
          oBusy <= 1'b0;
          oError <= 1'b1;
        end else begin
          remaining <= remaining - enc.oEncNumSamples;
          inPtr <= inPtr + enc.oEncNumSamples;
          outPtr <= oOutEnd;
          rstCnt <= '0;
          if (remaining == enc.oEncNumSamples) begin
            state <= SEQ_DONE;
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end else begin
            state <= SEQ_LOAD;
            oFrameIndex <= oFrameIndex + 16'd1;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flac_frame_sequencer.sv
// tb_flac_frame_sequencer: directed checks of frame splitting, chaining, guard, overflow, watchdog and reset
module tb_flac_frame_sequencer;
  logic iClock = 1'b0;
  logic iReset = 1'b1;
  logic iStart = 1'b0;
  logic [15:0] iTotalSamples = '0, iInBase = '0, iOutBase = '0;
  logic [15:0] oFrameIndex, oOutEnd;
  logic oFrameDone, oBusy, oDone, oError;
  int checks = 0, fails = 0, pulses = 0;
  logic staleMode = 1'b0, hangMode = 1'b0, ovfMode = 1'b0;
  logic mDone;
  logic [15:0] mAddr;
  int mCnt;
  int p0, cyc;

  flac_frame_sequencer_if enc();

  flac_frame_sequencer #(
    .BLOCK_SIZE(16'd16), .RESET_CYCLES(2), .OUT_LIMIT(16'h0020), .MAX_FRAME_CYCLES(32'd50)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iTotalSamples(iTotalSamples),
    .iInBase(iInBase), .iOutBase(iOutBase), .enc(enc), .oFrameIndex(oFrameIndex),
    .oFrameDone(oFrameDone), .oBusy(oBusy), .oDone(oDone), .oError(oError), .oOutEnd(oOutEnd)
  );

  always #5 iClock = ~iClock;

  assign enc.iEncDone = mDone;
  assign enc.iEncOutAddr = mAddr;

  always @(posedge iClock) if (oFrameDone) pulses <= pulses + 1;

  // encoder writes ceil(n/2)+3 words; returns the last written address
  function automatic logic [15:0] lastAddr(input logic [15:0] s, input logic [15:0] n);
    return s + (n + 16'd1) / 16'd2 + 16'd2;
  endfunction

  // encoder model: done rises on the 5th cycle out of reset and stays up until reset
  always @(posedge iClock) begin
    if (iReset) begin
      mDone <= 1'b0;
      mAddr <= '0;
      mCnt <= 0;
    end else if (enc.oEncReset) begin
      mCnt <= 0;
      if (!staleMode) mDone <= 1'b0;
    end else begin
      mCnt <= mCnt + 1;
      if (mCnt == 0) mDone <= 1'b0;
      if (!hangMode && mCnt == 4) begin
        mDone <= 1'b1;
        mAddr <= (ovfMode && enc.oEncInAddrStart == 16'd16) ? 16'h0021 : lastAddr(enc.oEncOutAddrStart, enc.oEncNumSamples);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic start(input logic [15:0] t, input logic [15:0] ib, input logic [15:0] ob);
    iTotalSamples = t;
    iInBase = ib;
    iOutBase = ob;
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
  endtask

  task automatic waitFrame(input string tag, input int lat, input logic [15:0] n, input logic [15:0] ib,
                           input logic [15:0] ob, input logic [15:0] oe, input logic [15:0] idx);
    int c = 0;
    do begin
      @(negedge iClock);
      c++;
    end while (!oFrameDone && c < 200);
    chk({tag, " latency"}, 32'(c), 32'(lat));
    chk({tag, " numSamples"}, 32'(enc.oEncNumSamples), 32'(n));
    chk({tag, " inStart"}, 32'(enc.oEncInAddrStart), 32'(ib));
    chk({tag, " outStart"}, 32'(enc.oEncOutAddrStart), 32'(ob));
    chk({tag, " outEnd"}, 32'(oOutEnd), 32'(oe));
    chk({tag, " frameIndex"}, 32'(oFrameIndex), 32'(idx));
  endtask

  initial begin
    tick(3);
    chk("rst encReset", 32'(enc.oEncReset), 32'd1);
    chk("rst busy", 32'(oBusy), 32'd0);
    chk("rst done", 32'(oDone), 32'd0);
    chk("rst error", 32'(oError), 32'd0);
    chk("rst outEnd", 32'(oOutEnd), 32'd0);
    chk("rst numSamples", 32'(enc.oEncNumSamples), 32'd0);
    iReset = 1'b0;
    tick(1);
    chk("idle encReset", 32'(enc.oEncReset), 32'd1);
    chk("idle frameDone", 32'(oFrameDone), 32'd0);

    p0 = pulses;
    start(16'd36, 16'd0, 16'd0);
    chk("t1 busy", 32'(oBusy), 32'd1);
    waitFrame("t1 f0", 8, 16'd16, 16'd0, 16'd0, 16'd11, 16'd0);
    waitFrame("t1 f1", 9, 16'd16, 16'd16, 16'd11, 16'd22, 16'd1);
    waitFrame("t1 f2", 9, 16'd4, 16'd32, 16'd22, 16'd27, 16'd2);
    tick(1);
    chk("t1 done", 32'(oDone), 32'd1);
    chk("t1 busy end", 32'(oBusy), 32'd0);
    chk("t1 outEnd", 32'(oOutEnd), 32'd27);
    chk("t1 encReset", 32'(enc.oEncReset), 32'd1);
    chk("t1 pulses", 32'(pulses - p0), 32'd3);

    p0 = pulses;
    start(16'd0, 16'd7, 16'h1234);
    chk("zero done", 32'(oDone), 32'd1);
    chk("zero busy", 32'(oBusy), 32'd0);
    chk("zero outEnd", 32'(oOutEnd), 32'h1234);
    chk("zero frameIndex", 32'(oFrameIndex), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("zero encReset", 32'(enc.oEncReset), 32'd1);
      tick(1);
    end
    chk("zero pulses", 32'(pulses - p0), 32'd0);

    staleMode = 1'b1;
    start(16'd20, 16'd100, 16'd0);
    waitFrame("stale f0", 8, 16'd16, 16'd100, 16'd0, 16'd11, 16'd0);
    waitFrame("stale f1", 9, 16'd4, 16'd116, 16'd11, 16'd16, 16'd1);
    tick(1);
    chk("stale done", 32'(oDone), 32'd1);
    staleMode = 1'b0;

    ovfMode = 1'b1;
    start(16'd36, 16'd0, 16'd0);
    waitFrame("ovf f0", 8, 16'd16, 16'd0, 16'd0, 16'd11, 16'd0);
    waitFrame("ovf f1", 9, 16'd16, 16'd16, 16'd11, 16'h0022, 16'd1);
    tick(1);
    chk("ovf error", 32'(oError), 32'd1);
    chk("ovf busy", 32'(oBusy), 32'd0);
    chk("ovf frameIndex", 32'(oFrameIndex), 32'd1);
    chk("ovf encReset", 32'(enc.oEncReset), 32'd1);
    chk("ovf done", 32'(oDone), 32'd0);
    ovfMode = 1'b0;

    hangMode = 1'b1;
    p0 = pulses;
    start(16'd5, 16'd0, 16'h0010);
    cyc = 0;
    while (!oError && cyc < 200) begin
      tick(1);
      cyc++;
    end
    chk("wd latency", 32'(cyc), 32'd53);
    chk("wd busy", 32'(oBusy), 32'd0);
    chk("wd encReset", 32'(enc.oEncReset), 32'd1);
    chk("wd pulses", 32'(pulses - p0), 32'd0);
    hangMode = 1'b0;
    start(16'd5, 16'd0, 16'h0010);
    chk("restart error", 32'(oError), 32'd0);
    chk("restart busy", 32'(oBusy), 32'd1);
    chk("restart frameIndex", 32'(oFrameIndex), 32'd0);
    waitFrame("restart f0", 8, 16'd5, 16'd0, 16'h0010, 16'h0016, 16'd0);
    tick(1);
    chk("restart done", 32'(oDone), 32'd1);

    start(16'd36, 16'd0, 16'd0);
    waitFrame("mr f0", 8, 16'd16, 16'd0, 16'd0, 16'd11, 16'd0);
    waitFrame("mr f1", 9, 16'd16, 16'd16, 16'd11, 16'd22, 16'd1);
    tick(4);
    start(16'd99, 16'h0500, 16'h0600);
    chk("ign numSamples", 32'(enc.oEncNumSamples), 32'd4);
    chk("ign inStart", 32'(enc.oEncInAddrStart), 32'd32);
    chk("ign outStart", 32'(enc.oEncOutAddrStart), 32'd22);
    chk("ign frameIndex", 32'(oFrameIndex), 32'd2);
    chk("ign busy", 32'(oBusy), 32'd1);
    chk("ign encReset", 32'(enc.oEncReset), 32'd0);
    iReset = 1'b1;
    tick(1);
    chk("mr encReset", 32'(enc.oEncReset), 32'd1);
    chk("mr busy", 32'(oBusy), 32'd0);
    chk("mr frameIndex", 32'(oFrameIndex), 32'd0);
    chk("mr numSamples", 32'(enc.oEncNumSamples), 32'd0);
    chk("mr inStart", 32'(enc.oEncInAddrStart), 32'd0);
    chk("mr outStart", 32'(enc.oEncOutAddrStart), 32'd0);
    chk("mr outEnd", 32'(oOutEnd), 32'd0);
    chk("mr done", 32'(oDone), 32'd0);
    chk("mr error", 32'(oError), 32'd0);
    chk("mr frameDone", 32'(oFrameDone), 32'd0);
    iReset = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
